// File: rtl/bcd_conv_sched_pkg.sv
// Shared constants for the BCD conversion scheduler: FSM state encodings,
// operand/result widths and the default WAIT timeout.
package bcd_conv_sched_pkg;

  localparam int BIN_W           = 8;
  localparam int BCD_W           = 12;
  localparam int TIMEOUT_DEFAULT = 63;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

endpackage

// File: rtl/bcd_conv_sched_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping at N_REQ-1 so non-power-of-two requester counts stay in range.
module bcd_conv_sched_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gid,
  output logic             any
);

  logic [2*N_REQ-1:0] rot_full;
  logic [N_REQ-1:0]   rot;
  int                 idx;

  // Rotating a doubled copy puts the requester at ptr in bit 0.
  assign rot_full = {req, req} >> ptr;
  assign rot      = rot_full[N_REQ-1:0];

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        idx = int'(ptr) + i;
        if (idx >= N_REQ) idx = idx - N_REQ;
      end
    end
    gid = ID_W'(idx);
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one external binary-to-BCD converter among
// N_REQ requesters. Optional per-requester result cache: BCD_SCHED_CACHE_EN.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_flat,
  output logic [N_REQ-1:0]       ack,
  output logic [BCD_W-1:0]       bcd_out,
  output logic [ID_W-1:0]        bcd_id,
  output logic                   bcd_valid,
  output logic                   err_timeout,
  output logic                   busy,
  output logic                   conv_en,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd,
  input  logic                   conv_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr, gid, id_reg, pick_gid, next_ptr;
  logic             pick_any, hit, timeout_hit;
  logic [BIN_W-1:0] op_reg, pick_bin;
  logic [BCD_W-1:0] res_reg, out_reg, hit_bcd;
  logic [CNT_W-1:0] cnt;

  bcd_conv_sched_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .gid (pick_gid),
    .any (pick_any)
  );

  assign pick_bin    = bin_flat[pick_gid*BIN_W +: BIN_W];
  assign next_ptr    = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
  // A converter strobe in the last WAIT cycle still wins over the fault.
  assign timeout_hit = (state == S_WAIT) && !conv_valid && (cnt == CNT_W'(TIMEOUT - 1));

`ifdef BCD_SCHED_CACHE_EN
  logic [BIN_W-1:0] cache_val [N_REQ];
  logic [BCD_W-1:0] cache_bcd [N_REQ];
  logic [N_REQ-1:0] cache_vld;

  assign hit     = cache_vld[pick_gid] && (cache_val[pick_gid] == pick_bin);
  assign hit_bcd = cache_bcd[pick_gid];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the cache storage is reset explicitly; a stale entry after reset would return a wrong BCD.
    if (!rst_n) begin
      cache_vld <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cache_val[i] <= '0;
        cache_bcd[i] <= '0;
      end
    end else if (state == S_WAIT && conv_valid) begin
      cache_vld[gid] <= 1'b1;
      cache_val[gid] <= op_reg;
      cache_bcd[gid] <= conv_bcd;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_bcd = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gid     <= '0;
      id_reg  <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      out_reg <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            gid    <= pick_gid;
            op_reg <= pick_bin;
            if (hit) begin
              res_reg <= hit_bcd;
              state   <= S_DELIVER;
            end else begin
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (conv_valid) begin
            res_reg <= conv_bcd;
            state   <= S_DELIVER;
          end else if (timeout_hit) begin
            ptr   <= next_ptr;
            state <= S_IDLE;
          end
        end
        S_DELIVER: begin
          out_reg <= res_reg;
          id_reg  <= gid;
          ptr     <= next_ptr;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign conv_en     = (state == S_ISSUE);
  assign conv_bin    = conv_en ? op_reg : '0;
  assign bcd_valid   = (state == S_DELIVER);
  assign ack         = bcd_valid ? (N_REQ'(1) << gid) : '0;
  // Result and id are shown live during DELIVER, then held until the next one.
  assign bcd_out     = bcd_valid ? res_reg : out_reg;
  assign bcd_id      = bcd_valid ? gid : id_reg;
  assign err_timeout = timeout_hit;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: vector table for single conversions,
// hand-written sequences for contention, timeout, stray strobes and reset.
module tb_bcd_conv_sched;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 63;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] bin_flat;
  logic [N_REQ-1:0]   ack;
  logic [11:0]        bcd_out;
  logic [ID_W-1:0]    bcd_id;
  logic               bcd_valid, err_timeout, busy, conv_en;
  logic [7:0]         conv_bin;
  logic [11:0]        conv_bcd;
  logic               conv_valid;

  bcd_conv_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .bin_flat    (bin_flat),
    .ack         (ack),
    .bcd_out     (bcd_out),
    .bcd_id      (bcd_id),
    .bcd_valid   (bcd_valid),
    .err_timeout (err_timeout),
    .busy        (busy),
    .conv_en     (conv_en),
    .conv_bin    (conv_bin),
    .conv_bcd    (conv_bcd),
    .conv_valid  (conv_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Converter model and event log.
  int         lat = 1;
  int         pend = 0;
  logic [7:0] cap;
  bit         stray = 0;
  bit         auto_drop = 1;
  int         cyc = 0, en_cnt = 0, en_cyc = 0, valid_cnt = 0, valid_cyc = 0;
  int         err_cnt = 0, err_cyc = 0;
  logic [7:0] en_bin;
  int         served[$];

  typedef struct {
    int         id;
    logic [7:0] val;
    int         lat;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    conv_valid = 1'b0;
    if (conv_en) begin
      en_cnt++;
      en_cyc = cyc;
      en_bin = conv_bin;
      cap    = conv_bin;
      pend   = lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        conv_valid = 1'b1;
        conv_bcd   = to_bcd(cap);
      end
    end
    if (stray) begin
      conv_valid = 1'b1;
      conv_bcd   = 12'hABC;
      stray      = 0;
    end
    #1;
    if (bcd_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      served.push_back(int'(bcd_id));
      check("ack_onehot", 32'(ack), 32'(1) << bcd_id);
      if (auto_drop) req[bcd_id] = 1'b0;
    end else if (ack != '0) begin
      check("ack_without_valid", 32'(ack), 32'd0);
    end
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < max_cyc && valid_cnt == v0; i++) tick();
    check("valid_arrived", 32'(valid_cnt != v0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    pend  = 0;
    conv_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, c0, v0, er0;
    int order_a[5];
    int order_b[4];
    int order_c[3];

    vecs[0] = '{0, 8'd255, 1, 12'h255};
    vecs[1] = '{1, 8'd0,   2, 12'h000};
    vecs[2] = '{2, 8'd9,   3, 12'h009};
    vecs[3] = '{3, 8'd99,  1, 12'h099};
    vecs[4] = '{0, 8'd100, 5, 12'h100};
    vecs[5] = '{1, 8'd128, 1, 12'h128};
    vecs[6] = '{2, 8'd42,  4, 12'h042};
    order_a = '{0, 1, 2, 3, 0};
    order_b = '{2, 3, 0, 1};
    order_c = '{3, 0, 2};

    req = '0; bin_flat = '0; conv_valid = 1'b0; conv_bcd = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_ack",       32'(ack), 32'd0);
    check("rst_valid",     32'(bcd_valid), 32'd0);
    check("rst_conv_en",   32'(conv_en), 32'd0);
    check("rst_conv_bin",  32'(conv_bin), 32'd0);
    check("rst_err",       32'(err_timeout), 32'd0);
    check("rst_bcd_out",   32'(bcd_out), 32'd0);
    check("rst_bcd_id",    32'(bcd_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single conversions; operand is scrambled after grant to prove it was latched.
    for (int k = 0; k < 7; k++) begin
      lat = vecs[k].lat;
      bin_flat[vecs[k].id*8 +: 8] = vecs[k].val;
      e0 = en_cnt;
      c0 = cyc;
      req[vecs[k].id] = 1'b1;
      tick();
      bin_flat[vecs[k].id*8 +: 8] = ~vecs[k].val;
      wait_valid(20);
      check("vec_bcd_out",  32'(bcd_out), 32'(vecs[k].exp_bcd));
      check("vec_bcd_id",   32'(bcd_id), 32'(vecs[k].id));
      check("vec_conv_en",  32'(en_cnt - e0), 32'd1);
      check("vec_conv_bin", 32'(en_bin), 32'(vecs[k].val));
      check("vec_latency",  32'(valid_cyc - c0), 32'(2 + vecs[k].lat));
      tick();
      check("vec_hold_bcd", 32'(bcd_out), 32'(vecs[k].exp_bcd));
      check("vec_pulse",    32'(bcd_valid), 32'd0);
    end

    // Stray converter strobe in IDLE must be ignored.
    v0 = valid_cnt;
    stray = 1;
    tick();
    tick();
    check("stray_busy",  32'(busy), 32'd0);
    check("stray_valid", 32'(valid_cnt - v0), 32'd0);

    // All four held continuously: plain rotation.
    do_reset();
    for (int i = 0; i < N_REQ; i++) bin_flat[i*8 +: 8] = 8'(11 * (i + 1));
    auto_drop = 0;
    lat = 1;
    served.delete();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_valid(20);
    req = '0;
    auto_drop = 1;
    for (int k = 0; k < 5; k++) check("rr_order", 32'(served[k]), 32'(order_a[k]));
    tick();
    tick();

    // Requester 1 arrives while 2 is being served: it goes last.
    served.delete();
    lat = 4;
    req = 4'b0100;
    tick();
    req[3] = 1'b1;
    req[0] = 1'b1;
    tick();
    tick();
    req[1] = 1'b1;
    for (int k = 0; k < 4; k++) wait_valid(30);
    for (int k = 0; k < 4; k++) check("late_order", 32'(served[k]), 32'(order_b[k]));
    tick();

    // Converter never answers: timeout, then next grant is gid+1.
    do_reset();
    served.delete();
    lat = 0;
    er0 = err_cnt;
    v0  = valid_cnt;
    req = 4'b0100;
    tick();
    req[3] = 1'b1;
    req[0] = 1'b1;
    for (int i = 0; i < TIMEOUT + 10 && err_cnt == er0; i++) tick();
    check("to_arrived", 32'(err_cnt - er0), 32'd1);
    check("to_cycles",  32'(err_cyc - en_cyc), 32'(TIMEOUT));
    check("to_no_ack",  32'(valid_cnt - v0), 32'd0);
    lat = 1;
    for (int k = 0; k < 3; k++) wait_valid(20);
    for (int k = 0; k < 3; k++) check("to_order", 32'(served[k]), 32'(order_c[k]));
    check("to_single_pulse", 32'(err_cnt - er0), 32'd1);
    tick();

    // Reset while waiting on the converter.
    lat = 0;
    bin_flat[7:0] = 8'd77;
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",    32'(busy), 32'd0);
    check("mid_rst_bcd_out", 32'(bcd_out), 32'd0);
    check("mid_rst_bcd_id",  32'(bcd_id), 32'd0);
    check("mid_rst_outs",    32'({ack, bcd_valid, err_timeout, conv_en, conv_bin}), 32'd0);
    req  = '0;
    pend = 0;
    tick();
    rst_n = 1'b1;
    lat = 2;
    bin_flat[15:8] = 8'd63;
    c0 = cyc;
    req = 4'b0010;
    wait_valid(20);
    check("post_rst_id",  32'(bcd_id), 32'd1);
    check("post_rst_bcd", 32'(bcd_out), 32'h063);
    check("post_rst_lat", 32'(valid_cyc - c0), 32'd4);
    tick();

`ifdef BCD_SCHED_CACHE_EN
    lat = 1;
    bin_flat[15:8] = 8'd42;
    req = 4'b0010;
    wait_valid(20);
    tick();
    e0 = en_cnt;
    c0 = cyc;
    req = 4'b0010;
    wait_valid(20);
    check("cache_no_conv", 32'(en_cnt - e0), 32'd0);
    check("cache_bcd",     32'(bcd_out), 32'h042);
    check("cache_fast",    32'(valid_cyc - c0 <= 2), 32'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
